led_pattern_sequencer: RTL and testbench

Parametrised successor to the board-level counter/BRAM LED demo. Generates a step-enable tick from a prescaler and drives an address counter over an internal DEPTH-entry pattern RAM. Supports up/down wrap or bounce sweep, and separate record and playback modes. The registered pattern output feeds the LED and Arduino GPIO pins. One instance per LED bank.

---
 rtl/led_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a prescaled step tick sweeps an address (wrap or bounce) over a
// DEPTH-entry pattern RAM that is recorded with a generated pattern or played back.
// Optional: define SEQ_GRAY_EN to record Gray-coded addresses instead of bit-reversed ones.
module led_pattern_sequencer #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000000,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              dir,
    input  logic              bounce,
    input  logic              play,
    output logic              tick_o,
    output logic [AW-1:0]     addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              phase_o,
    output logic              wrap_o,
    output logic              dbg_dir_up_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (DATA_W > AW) ? DATA_W : AW;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_TURN  = AW'(DEPTH - 2);

    // Bounce-mode sweep direction; tracks dir whenever bounce is low.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    dir_e              state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              phase_q, phase_d;
    logic              tick_q;
    logic              wrap_q, wrap_d;
    logic              tick_c;
    logic              ram_we;
    logic [DATA_W-1:0] pat_c;
    logic [DATA_W-1:0] ram_q [DEPTH];

    function automatic logic [DATA_W-1:0] pat_f(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        logic [MW-1:0] w;
`ifdef SEQ_GRAY_EN
        p = a ^ (a >> 1);
`else
        p = '0;
        for (int i = 0; i < AW; i++) begin
            p[i] = a[AW-1-i];
        end
`endif
        w = '0;
        w[AW-1:0] = p;
        return w[DATA_W-1:0];
    endfunction

    assign tick_c = en && (presc_q == PRESC_LAST);
    assign pat_c  = pat_f(addr_q);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q + PW'(1);
        addr_d  = addr_q;
        data_d  = data_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        ram_we  = 1'b0;

        if (!en || tick_c) begin
            presc_d = '0;
        end

        if (tick_c) begin
            // Data always reflects the pre-advance address.
            if (play) begin
                data_d = ram_q[addr_q];
            end else begin
                data_d = pat_c;
                ram_we = 1'b1;
            end

            if (!bounce) begin
                if (dir) begin
                    addr_d = addr_q + AW'(1);
                    wrap_d = (addr_q == ADDR_LAST);
                end else begin
                    addr_d = addr_q - AW'(1);
                    wrap_d = (addr_q == '0);
                end
            end else begin
                case (state_q)
                    DIR_UP: begin
                        if (addr_q == ADDR_LAST) begin
                            state_d = DIR_DOWN;
                            addr_d  = ADDR_TURN;
                            wrap_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                    DIR_DOWN: begin
                        if (addr_q == '0) begin
                            state_d = DIR_UP;
                            addr_d  = AW'(1);
                            wrap_d  = 1'b1;
                        end else begin
                            addr_d = addr_q - AW'(1);
                        end
                    end
                    default: state_d = DIR_UP;
                endcase
            end

            if (wrap_d) begin
                phase_d = ~phase_q;
            end
        end

        if (!bounce) begin
            state_d = dir ? DIR_UP : DIR_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= DIR_UP;
            presc_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            phase_q <= 1'b1;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            tick_q  <= tick_c;
            wrap_q  <= wrap_d;
        end
    end

    // Pattern storage is deliberately not reset; a tick during reset must not write.
    always_ff @(posedge clk) begin
        if (reset_n && ram_we) begin
            ram_q[addr_q] <= pat_c;
        end
    end

    assign tick_o       = tick_q;
    assign addr_o       = addr_q;
    assign data_o       = data_q;
    assign phase_o      = phase_q;
    assign wrap_o       = wrap_q;
    assign dbg_dir_up_o = (state_q == DIR_UP);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: two instances (16x4 with divide-by-3, 4x4 with divide-by-1)
// against an arithmetic reference model, plus hand-computed sequence checks.
module tb_led_pattern_sequencer;

    logic clk = 1'b0;
    logic reset_n, en, dir, bounce, play;

    logic       tick0, phase0, wrap0, dbg0;
    logic [3:0] addr0;
    logic [3:0] data0;
    logic       tick1, phase1, wrap1, dbg1;
    logic [1:0] addr1;
    logic [3:0] data1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_presc[2], m_addr[2], m_data[2];
    bit m_phase[2], m_tick[2], m_wrap[2], m_up[2], m_dvalid[2];
    int m_ram[2][16];
    bit m_rvalid[2][16];
    int lit_pat[16];

    always #5 clk = ~clk;

    led_pattern_sequencer #(.DATA_W(4), .DEPTH(16), .TICK_DIV(3)) u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .bounce(bounce), .play(play),
        .tick_o(tick0), .addr_o(addr0), .data_o(data0), .phase_o(phase0), .wrap_o(wrap0),
        .dbg_dir_up_o(dbg0)
    );

    led_pattern_sequencer #(.DATA_W(4), .DEPTH(4), .TICK_DIV(1)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .bounce(bounce), .play(play),
        .tick_o(tick1), .addr_o(addr1), .data_o(data1), .phase_o(phase1), .wrap_o(wrap1),
        .dbg_dir_up_o(dbg1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pat(input int aw, input int a);
        int r;
        r = 0;
`ifdef SEQ_GRAY_EN
        r = a ^ (a >> 1);
`else
        for (int i = 0; i < aw; i++) begin
            if ((a & (1 << i)) != 0) r = r | (1 << (aw - 1 - i));
        end
`endif
        return r & 15;
    endfunction

    // Reference model: one call per rising edge, using the inputs that are stable at that edge.
    task automatic model_step(input int k);
        int  depth, tdiv, aw, nxt;
        bit  tick, wr;
        depth = (k == 1) ? 4 : 16;
        tdiv  = (k == 1) ? 1 : 3;
        aw    = (k == 1) ? 2 : 4;
        if (!reset_n) begin
            m_presc[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_dvalid[k] = 1'b1;
            m_phase[k] = 1'b1; m_tick[k] = 1'b0; m_wrap[k] = 1'b0; m_up[k] = 1'b1;
            return;
        end
        tick = en && (m_presc[k] == tdiv - 1);
        m_presc[k] = (en && !tick) ? m_presc[k] + 1 : 0;
        m_tick[k] = tick;
        m_wrap[k] = 1'b0;
        if (tick) begin
            if (play) begin
                m_data[k]   = m_ram[k][m_addr[k]];
                m_dvalid[k] = m_rvalid[k][m_addr[k]];
            end else begin
                m_data[k] = pat(aw, m_addr[k]);
                m_ram[k][m_addr[k]]    = m_data[k];
                m_rvalid[k][m_addr[k]] = 1'b1;
                m_dvalid[k] = 1'b1;
            end
            nxt = ((bounce ? m_up[k] : dir) != 0) ? m_addr[k] + 1 : m_addr[k] - 1;
            wr  = (nxt < 0) || (nxt >= depth);
            if (!bounce) begin
                nxt = (nxt + depth) % depth;
            end else if (wr) begin
                m_up[k] = !m_up[k];
                nxt = m_up[k] ? 1 : depth - 2;
            end
            m_addr[k] = nxt;
            m_wrap[k] = wr;
            if (wr) m_phase[k] = !m_phase[k];
        end
        if (!bounce) m_up[k] = dir;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0_tick", int'(tick0), int'(m_tick[0]));
            chk("u0_addr", int'(addr0), m_addr[0]);
            chk("u0_phase", int'(phase0), int'(m_phase[0]));
            chk("u0_wrap", int'(wrap0), int'(m_wrap[0]));
            chk("u0_dir", int'(dbg0), int'(m_up[0]));
            if (m_dvalid[0]) chk("u0_data", int'(data0), m_data[0]);
            chk("u1_tick", int'(tick1), int'(m_tick[1]));
            chk("u1_addr", int'(addr1), m_addr[1]);
            chk("u1_phase", int'(phase1), int'(m_phase[1]));
            chk("u1_wrap", int'(wrap1), int'(m_wrap[1]));
            chk("u1_dir", int'(dbg1), int'(m_up[1]));
            if (m_dvalid[1]) chk("u1_data", int'(data1), m_data[1]);
        end
    end

    task automatic wait_tick0(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick0 && n < 40);
        if (!tick0) chk("tick_timeout", int'(tick0), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"}, int'(addr0), 0);
        chk({tag, "_data"}, int'(data0), 0);
        chk({tag, "_phase"}, int'(phase0), 1);
        chk({tag, "_tick"}, int'(tick0), 0);
        chk({tag, "_wrap"}, int'(wrap0), 0);
    endtask

    int n, cnt;
    int bounce_exp[8];

    initial begin
`ifdef SEQ_GRAY_EN
        lit_pat = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
`else
        lit_pat = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`endif
        bounce_exp = '{0, 1, 2, 3, 2, 1, 0, 1};
        reset_n = 1'b0; en = 1'b0; dir = 1'b1; bounce = 1'b0; play = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk_reset_state("reset");

        // Record pass: up-count with wrap.
        reset_n = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_tick0(n);
            chk("rec_gap", n, 3);
            chk("rec_addr", int'(addr0), i % 16);
            chk("rec_data", int'(data0), lit_pat[i-1]);
            chk("rec_wrap", int'(wrap0), (i == 16) ? 1 : 0);
        end
        chk("rec_phase", int'(phase0), 0);

        // Playback pass from address 0.
        play = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_tick0(n);
            chk("play_data", int'(data0), lit_pat[i-1]);
            chk("play_addr", int'(addr0), i % 16);
        end

        // Down wrap, then a direction flip mid-sweep.
        dir = 1'b0;
        wait_tick0(n);
        chk("down_addr", int'(addr0), 15);
        chk("down_wrap", int'(wrap0), 1);
        chk("down_phase", int'(phase0), 0);
        wait_tick0(n);
        wait_tick0(n);
        chk("down_addr2", int'(addr0), 13);
        @(negedge clk);
        dir = 1'b1;
        wait_tick0(n);
        chk("flip_gap", n, 2);
        chk("flip_addr", int'(addr0), 14);
        chk("flip_data", int'(data0), lit_pat[13]);

        // Enable gating mid-count.
        @(negedge clk);
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick0) cnt++;
        end
        chk("gate_no_tick", cnt, 0);
        chk("gate_addr_held", int'(addr0), 14);
        en = 1'b1;
        wait_tick0(n);
        chk("gate_first_tick", n, 3);
        chk("gate_addr", int'(addr0), 15);

        // Reset at address 9 during playback; RAM must survive.
        cnt = 0;
        do begin
            wait_tick0(n);
            cnt++;
        end while (addr0 != 4'd9 && cnt < 20);
        chk("reach_addr9", int'(addr0), 9);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_state("midreset");
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_tick0(n);
            chk("retain_data", int'(data0), lit_pat[i-1]);
            chk("retain_addr", int'(addr0), i);
        end

        // Bounce sweep; u1 steps every cycle.
        @(negedge clk);
        reset_n = 1'b0;
        bounce = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("bnc_addr", int'(addr1), bounce_exp[i]);
            chk("bnc_wrap", int'(wrap1), (i == 4 || i == 7) ? 1 : 0);
            if (i == 5) chk("bnc_phase_mid", int'(phase1), 0);
        end
        chk("bnc_phase_end", int'(phase1), 1);

        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!wrap0 && cnt < 80);
        chk("bnc16_wrap", int'(wrap0), 1);
        chk("bnc16_addr", int'(addr0), 14);
        chk("bnc16_dir", int'(dbg0), 0);
        wait_tick0(n);
        chk("bnc16_addr2", int'(addr0), 13);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
